code_sequencer: RTL

- Sequential controller that drives the 4-bit input code of the team's combinational 4-in/12-out pattern decoder and registers the decoder's 12 outputs for display.
- Steps the code automatically (up or down, prescaled), manually (one step per button press), or holds it; supports parallel load.
- Sits between board switches/buttons and the decoder; the decoder itself stays purely combinational.

---
 rtl/code_sequencer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/code_sequencer.sv
// -----------------------------------------------------------------------------
// code_sequencer
//
// Purpose:
//   Drives the 4-bit input code of the combinational 4-in/12-out pattern
//   decoder and registers the decoder's 12 outputs for display.  The code
//   is stepped automatically (up or down, prescaled by DIV), manually (one
//   up-step per button press), or held.  A parallel load overrides any step.
//
// Parameters:
//   DIV        clock cycles per automatic step (>= 2)
//   CODE_MAX   highest code value, range 0..CODE_MAX (<= 15)
//   DEB_CYCLES stable-count for the step button (debounce build only)
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   en_i         global enable; 0 freezes code, prescaler and FSM (load works)
//   mode_i       00 HOLD, 01 AUTO_UP, 10 AUTO_DOWN, 11 MANUAL
//   step_btn_i   asynchronous push-button, active-high (MANUAL mode)
//   load_i       synchronous parallel-load strobe
//   load_val_i   value to load (clamped to CODE_MAX)
//   seg_in_i     decoder outputs {a..k,x} for the current code
//   code_o       registered code to decoder inputs {I1,I2,I3,I4}, I1 = MSB
//   seg_out_o    registered copy of seg_in_i
//   tick_o       one-cycle pulse on every code step (not on load)
//   wrap_o       one-cycle pulse on a CODE_MAX->0 or 0->CODE_MAX step
//
// Build option:
//   DEBOUNCE_EN  when defined, the synchronized button must be stable for
//                DEB_CYCLES consecutive cycles before its level is accepted;
//                press-to-code latency grows from 3 to 3+DEB_CYCLES cycles.
// -----------------------------------------------------------------------------
module code_sequencer #(
    parameter int DIV        = 4,
    parameter int CODE_MAX   = 15,
    parameter int DEB_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [1:0]  mode_i,
    input  logic        step_btn_i,
    input  logic        load_i,
    input  logic [3:0]  load_val_i,
    input  logic [11:0] seg_in_i,
    output logic [3:0]  code_o,
    output logic [11:0] seg_out_o,
    output logic        tick_o,
    output logic        wrap_o
);

    localparam int              PW       = $clog2(DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [3:0]      CMAX     = 4'(CODE_MAX);

    if (DIV < 2 || CODE_MAX < 1 || CODE_MAX > 15 || DEB_CYCLES < 1) begin : g_param_check
        $error("code_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_HOLD = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10,
        S_MAN  = 2'b11
    } state_e;

    // Saturate a loaded value into the legal code range.
    function automatic logic [3:0] clamp_code(input logic [3:0] v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic logic [3:0] code_inc(input logic [3:0] c);
        return (c == CMAX) ? 4'd0 : c + 4'd1;
    endfunction

    function automatic logic [3:0] code_dec(input logic [3:0] c);
        return (c == 4'd0) ? CMAX : c - 4'd1;
    endfunction

    function automatic state_e mode_to_state(input logic [1:0] m);
        case (m)
            2'b01:   return S_UP;
            2'b10:   return S_DOWN;
            2'b11:   return S_MAN;
            default: return S_HOLD;
        endcase
    endfunction

    state_e         state_q, state_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic [3:0]     code_q, code_d;
    logic [11:0]    seg_q;
    logic           tick_q, tick_d;
    logic           wrap_q, wrap_d;

    // Button path: 2-FF synchronizer, optional debounce, rising-edge detect.
    logic           btn_s1_q, btn_s2_q;
    logic           btn_prev_q;
    logic           btn_lvl;
    logic           btn_rise;

`ifdef DEBOUNCE_EN
    localparam int             DCW      = $clog2(DEB_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

    logic           btn_deb_q, btn_deb_d;
    logic [DCW-1:0] deb_cnt_q, deb_cnt_d;

    // The counter measures how long the synchronized level has disagreed
    // with the accepted level; any agreement restarts the count.
    always_comb begin
        btn_deb_d = btn_deb_q;
        deb_cnt_d = '0;
        if (btn_s2_q != btn_deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_deb_d = btn_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign btn_lvl = btn_deb_q;
`else
    assign btn_lvl = btn_s2_q;
`endif

    // The edge register tracks the level in every mode, so a button held
    // across a mode change never produces a stale step later.
    assign btn_rise = btn_lvl & ~btn_prev_q;

    logic step_up_req;
    logic step_dn_req;

    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        code_d      = code_q;
        tick_d      = 1'b0;
        wrap_d      = 1'b0;
        step_up_req = 1'b0;
        step_dn_req = 1'b0;

        if (en_i) begin
            state_d = mode_to_state(mode_i);
            case (state_q)
                S_UP, S_DOWN: begin
                    if (pre_q == PRE_LAST) begin
                        pre_d       = '0;
                        step_up_req = (state_q == S_UP);
                        step_dn_req = (state_q == S_DOWN);
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                S_MAN: begin
                    pre_d       = '0;
                    step_up_req = btn_rise;
                end
                default: begin
                    pre_d = '0;
                end
            endcase
            // A new mode always starts a full prescale period.
            if (state_d != state_q) begin
                pre_d = '0;
            end
        end

        // Load wins over any step due in the same cycle; the step is dropped.
        if (load_i) begin
            code_d = clamp_code(load_val_i);
            pre_d  = '0;
        end else if (step_up_req) begin
            code_d = code_inc(code_q);
            tick_d = 1'b1;
            wrap_d = (code_q == CMAX);
        end else if (step_dn_req) begin
            code_d = code_dec(code_q);
            tick_d = 1'b1;
            wrap_d = (code_q == 4'd0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_HOLD;
            pre_q      <= '0;
            code_q     <= 4'd0;
            seg_q      <= 12'd0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
`ifdef DEBOUNCE_EN
            btn_deb_q  <= 1'b0;
            deb_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            code_q     <= code_d;
            seg_q      <= seg_in_i;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            btn_s1_q   <= step_btn_i;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_lvl;
`ifdef DEBOUNCE_EN
            btn_deb_q  <= btn_deb_d;
            deb_cnt_q  <= deb_cnt_d;
`endif
        end
    end

    assign code_o    = code_q;
    assign seg_out_o = seg_q;
    assign tick_o    = tick_q;
    assign wrap_o    = wrap_q;

endmodule
